// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface divider_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider with a fixed 33-cycle latency.
module divider (
    input  logic     clk,
    input  logic     reset_n,
    divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  count;
    logic        rem_sel;
    logic        is_signed;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [31:0] divisor_abs;
    logic [63:0] acc;           // {rem, quo}
    logic        done_q;
    logic [31:0] result_q;

    logic        accept;
    logic        op_signed;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs_in;
    logic [63:0] shifted;
    logic [33:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept = bus.start && !bus.flush;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_signed      = !bus.op[0];
        dividend_abs   = (op_signed && bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
        divisor_abs_in = (op_signed && bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;

        // The bit shifted out of rem[31] joins the trial so divisors >= 2^31 stay exact.
        shifted = {acc[62:0], 1'b0};
        diff    = {1'b0, acc[63], shifted[63:32]} - {2'b00, divisor_abs};

        q_fix = (is_signed && (sign_a ^ sign_b)) ? (~acc[31:0] + 32'd1) : acc[31:0];
        // With a zero divisor every trial succeeds, so rem already holds |dividend|
        // and the sign fix-up below restores the original dividend exactly.
        r_fix = (is_signed && sign_a) ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (div_zero) begin
            q_fix = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CALC;
            CALC: begin
                if (bus.flush)          next_state = IDLE;
                else if (count == 5'd31) next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= 5'd0;
            rem_sel     <= 1'b0;
            is_signed   <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div_zero    <= 1'b0;
            divisor_abs <= 32'd0;
            acc         <= 64'd0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_sel     <= bus.op[1];
                        is_signed   <= op_signed;
                        sign_a      <= bus.dividend[31];
                        sign_b      <= bus.divisor[31];
                        div_zero    <= (bus.divisor == 32'd0);
                        divisor_abs <= divisor_abs_in;
                        acc         <= {32'd0, dividend_abs};
                        count       <= 5'd0;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        if (!diff[33]) acc <= {diff[31:0], shifted[31:1], 1'b1};
                        else           acc <= shifted;
                        count <= count + 5'd1;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        result_q <= rem_sel ? r_fix : q_fix;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the iterative divider.
module tb_divider;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    divider_if bus ();

    divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        int n;
        drive(op, a, b);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd33);
        check({tag, " result"}, bus.result, expected);
        check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // Watch for a stray done pulse over a fixed window.
    task automatic expect_no_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        drive(OP_DIV, 32'd0, 32'd0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);

        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op("div 0/0", OP_DIV, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_op("divu big divisor", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        run_op("remu big divisor", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);

        // A second start at cycle 10 lands in CALC and must be ignored.
        drive(OP_DIVU, 32'd50, 32'd5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
            if (n == 10) begin
                drive(OP_DIV, 32'd1000, 32'd7);
                bus.start = 1'b1;
            end
            if (n == 11) bus.start = 1'b0;
        end
        check("ignored start latency", 32'(n), 32'd33);
        check("ignored start result", bus.result, 32'd10);

        // Start held high: the next request is taken in the done cycle.
        drive(OP_DIVU, 32'd60, 32'd5);
        bus.start = 1'b1;
        tick();
        drive(OP_DIVU, 32'd81, 32'd9);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("b2b first latency", 32'(n), 32'd33);
        check("b2b first result", bus.result, 32'd12);
        tick();
        bus.start = 1'b0;
        check("b2b accepted busy", {31'd0, bus.busy}, 32'd1);
        check("b2b done cleared", {31'd0, bus.done}, 32'd0);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("b2b second latency", 32'(n), 32'd33);
        check("b2b second result", bus.result, 32'd9);

        // Flush at cycle 15 of an operation.
        drive(OP_DIVU, 32'd1000, 32'd10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", {31'd0, bus.busy}, 32'd0);
        check("flush done", {31'd0, bus.done}, 32'd0);
        check("flush result kept", bus.result, 32'd9);
        expect_no_done("flush no done");

        // Flush in IDLE beats a simultaneous start.
        drive(OP_DIVU, 32'd8, 32'd2);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush+start busy", {31'd0, bus.busy}, 32'd0);
        expect_no_done("flush+start no done");
        check("flush+start result kept", bus.result, 32'd9);

        // Synchronous reset at cycle 20 of an operation.
        drive(OP_DIVU, 32'd1000, 32'd10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset_n = 1'b0;
        tick();
        check("midop reset busy", {31'd0, bus.busy}, 32'd0);
        check("midop reset done", {31'd0, bus.done}, 32'd0);
        check("midop reset result", bus.result, 32'd0);
        reset_n = 1'b1;
        tick();
        run_op("divu 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
